// File: rtl/lsu_mem_responder_if.sv
// Load/store request and response bundle between the MEM-stage pipeline and the
// data-memory responder.
interface lsu_mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        misaligned;

  modport master (
    output mem_read, mem_write, funct3, addr, wdata,
    input  stall, rdata, rdata_valid, misaligned
  );

  modport slave (
    input  mem_read, mem_write, funct3, addr, wdata,
    output stall, rdata, rdata_valid, misaligned
  );
endinterface

// File: rtl/lsu_mem_responder.sv
// MEM-stage data memory: byte/half/word loads and stores with fixed wait states.
// Optional macro LSU_MISALIGN_TRAP_EN rejects misaligned H/W accesses instead of aligning them.
//
// state | meaning
// IDLE  | waiting for mem_read/mem_write; stall follows the request
// BUSY  | counting down wait cycles; access performed on the edge where cnt==0
// DONE  | one-cycle result slot; stall low so the pipeline advances
module lsu_mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input logic               clk,
  input logic               rst,
  lsu_mem_responder_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        op_wr;
  logic [2:0]  f3_q;
  logic [AW+1:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] mem [DEPTH];

  logic        req, accept, perform, reject;
  logic [AW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wlane, rword, rext;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] rdata_q;
  logic        rdata_valid_q;
  logic        unused_addr;

  assign req         = bus.mem_read | bus.mem_write;
  assign accept      = (state == IDLE) && req;
  assign perform     = (state == BUSY) && (cnt == 4'd0);
  assign idx         = addr_q[AW+1:2];
  // address bits above the array size wrap and are deliberately ignored
  assign unused_addr = ^bus.addr[31:AW+2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= 4'(LATENCY);
      else if (state == BUSY && cnt != 4'd0)
        cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.stall = accept || (state == BUSY);
  end

  // a simultaneous read and write is treated as a store
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_wr   <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      op_wr   <= bus.mem_write;
      f3_q    <= bus.funct3;
      addr_q  <= bus.addr[AW+1:0];
      wdata_q <= bus.wdata;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;

  assign reject = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                  ((f3_q == 3'b010) && (addr_q[1:0] != 2'b00));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= perform && reject;
  end

  assign bus.misaligned = mis_q;
`else
  assign reject         = 1'b0;
  assign bus.misaligned = 1'b0;
`endif

  // lane selection ignores addr[0] for halves and addr[1:0] for words, which aligns them
  always_comb begin
    be    = 4'b0000;
    wlane = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wlane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (perform && op_wr && !reject) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
    end
  end

  always_comb begin
    rword = mem[idx];
    rbyte = rword[{addr_q[1:0], 3'b000} +: 8];
    rhalf = addr_q[1] ? rword[31:16] : rword[15:0];
    case (f3_q)
      3'b000:  rext = {{24{rbyte[7]}}, rbyte};
      3'b001:  rext = {{16{rhalf[15]}}, rhalf};
      3'b010:  rext = rword;
      3'b100:  rext = {24'd0, rbyte};
      3'b101:  rext = {16'd0, rhalf};
      default: rext = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
    end else begin
      rdata_valid_q <= perform && !op_wr && !reject;
      if (perform && !op_wr && !reject)
        rdata_q <= rext;
    end
  end

  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
endmodule

// File: doc/lsu_mem_responder.md
# lsu_mem_responder

Data-memory responder for the RISC-V datapath: it services the load/store requests raised by the main controller's MemRead/MemWrite decode. It holds an internal word-addressed data array and performs byte, halfword and word accesses selected by funct3, with sign or zero extension on loads. Each access takes a parameterised number of wait cycles, and the block holds the pipeline with `stall` until the access completes. It sits in the MEM stage, between the ALU result (address) and the write-back mux (Memtoreg path).

## Interface
- `DEPTH`, 1024: number of 32-bit words in the array; power of two.
- `LATENCY`, 2: extra wait cycles per access (0..15).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `mem_read` input 1: load request; held stable while `stall`=1.
- `mem_write` input 1: store request; held stable while `stall`=1.
- `funct3` input 3: size code. 000=B, 001=H, 010=W, 100=BU, 101=HU; stores use 000/001/010.
- `addr` input 32: byte address (ALU result).
- `wdata` input 32: store data (rs2); low bits are used for B/H.
- `stall` output 1: pipeline hold; combinational from state and request.
- `rdata` output 32: extended load result; valid when `rdata_valid`=1.
- `rdata_valid` output 1: one-cycle pulse in DONE for loads.
- `misaligned` output 1: one-cycle pulse in DONE for a rejected access (macro builds only).

## Operation
- FSM has three states: IDLE, BUSY, DONE. 4-bit down-counter `cnt`.
- IDLE with `mem_read|mem_write`=1:
  - latch `addr`, `wdata`, `funct3` and the op;
  - set `cnt`=LATENCY; go to BUSY.
  - If both requests are high, the op is a store and the read is ignored.
- BUSY:
  - `cnt`!=0: decrement.
  - `cnt`==0: perform the access on this edge; go to DONE.
- DONE: drive results for one cycle; go to IDLE unconditionally.
- Word index is `addr[log2(DEPTH)+1:2]`; higher bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
- Stores: byte-lane write. SB writes lane `addr[1:0]`, SH writes lanes {addr[1],0}+{0,1}, SW writes all four lanes; other lanes are unchanged.
- Loads: select the lane(s), then extend. B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through. Reserved funct3 values (011, 110, 111) return 0.
- `stall` = (IDLE & request) | BUSY. It is low in DONE, so the pipeline advances at the end of DONE.

## Timing
- Acceptance is cycle 0. `stall` is high in cycles 0..LATENCY+1. DONE is cycle LATENCY+2.
- A store's array update is visible to a load accepted in any later cycle.
- `rdata` and `rdata_valid` are registered and set on the edge entering DONE. `rdata` holds its value until the next load completes; `rdata_valid` is cleared on leaving DONE.
- Back-to-back: a new request in the cycle after DONE is accepted immediately, giving LATENCY+3 cycles per access.
- Reset values: state=IDLE, `cnt`=0, `rdata`=0, `rdata_valid`=0, `misaligned`=0. With no request, `stall`=0.
- Reset asserted mid-access aborts the access. If reset arrives before the performing edge, no array write occurs. Array contents are never reset.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - An H/HU access with addr[0]=1, or a W access with addr[1:0]!=0, is rejected.
  - A rejected store leaves the array unchanged; a rejected load leaves `rdata` unchanged and does not assert `rdata_valid`.
  - `misaligned` pulses in DONE. Latency is identical to a normal access.
- Undefined: `misaligned` is tied to 0. Misaligned addresses are forced aligned (H clears addr[0]; W clears addr[1:0]) and the access proceeds.

## Test plan
- Reset, LATENCY=2: SW addr 0x10 data 0xDEADBEEF -> `stall` high 4 cycles, low in cycle 4; LW 0x10 -> `rdata`=0xDEADBEEF with `rdata_valid` pulse in cycle 4.
- SB 0x13 data 0x000000F0 over word 0x11223344; then LB 0x13 -> 0xFFFFFFF0; LBU 0x13 -> 0x000000F0; LW 0x10 -> 0xF0223344.
- SH 0x22 data 0x8001; then LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001. A load of word 0x20 shows lanes 0..1 unchanged.
- `mem_read` and `mem_write` both high with addr 0x40 data 0x5 -> treated as a store; no `rdata_valid` pulse; a following LW 0x40 returns 0x5.
- Assert `rst` in BUSY during SW 0x50 data 0x1234 (word previously 0x0) -> outputs return to reset values asynchronously; a following LW 0x50 returns 0x0.
- Macro defined: LW 0x31 -> `misaligned` pulse in DONE, no `rdata_valid`. Macro undefined: the same LW returns the word at 0x30 with `misaligned`=0.
